// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready issue, a result
// strobe and an iterative restoring divider.
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic [WIDTH-1:0] ALU_REM,
  output logic             Arith_Flag,
  output logic             Logic_Flag,
  output logic             Cmp_Flag,
  output logic             Shift_Flag,
  output logic             Div0_Flag
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef enum logic {
    IDLE,
    DIV
  } state_t;

  state_t state_q;
  state_t state_d;

  logic               accept;
  logic               start_div;
  logic               div_done;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] p_q;
  logic [2*WIDTH-1:0] p_d;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH:0]     r_sh;
  logic [WIDTH-1:0]   r_diff;
  logic               r_ge;

  logic [WIDTH-1:0]   s_out;
  logic [WIDTH-1:0]   s_rem;
  logic [4:0]         s_fl;
  logic [SHW-1:0]     sh;

  assign sh = B[SHW-1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    IN_READY  = 1'b0;
    accept    = 1'b0;
    start_div = 1'b0;
    div_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        IN_READY  = 1'b1;
        accept    = IN_VALID;
        start_div = IN_VALID && (ALU_FUN == OP_DIV)
                    && (|B);
        if (start_div) state_d = DIV;
      end
      DIV: begin
        div_done = (cnt_q == LAST);
        if (div_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit and
  // subtract the divisor when it fits (WIDTH+1 bit compare).
  always_comb begin
    r_sh   = p_q[2*WIDTH-1:WIDTH-1];
    r_ge   = (r_sh >= {1'b0, dvs_q});
    r_diff = WIDTH'(r_sh - {1'b0, dvs_q});
    p_d    = {p_q[2*WIDTH-2:0], 1'b0};
    if (r_ge) begin
      p_d = {r_diff, p_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      p_q   <= '0;
      dvs_q <= '0;
    end else if (start_div) begin
      cnt_q <= '0;
      p_q   <= {{WIDTH{1'b0}}, A};
      dvs_q <= B;
    end else if (state_q == DIV && !div_done) begin
      cnt_q <= cnt_q + CW'(1);
      p_q   <= p_d;
    end
  end

  // Flags packed as {arith, logic, cmp, shift, div0}.
  always_comb begin
    s_out = '0;
    s_rem = '0;
    s_fl  = 5'b00000;
    unique case (ALU_FUN)
      4'b0000: begin
        s_out = A + B;
        s_fl  = 5'b10000;
      end
      4'b0001: begin
        s_out = A - B;
        s_fl  = 5'b10000;
      end
      4'b0010: begin
        s_out = A * B;
        s_fl  = 5'b10000;
      end
      4'b0011: begin
        s_out = '1;
        s_rem = A;
        s_fl  = 5'b10001;
      end
      4'b0100: begin
        s_out = A & B;
        s_fl  = 5'b01000;
      end
      4'b0101: begin
        s_out = A | B;
        s_fl  = 5'b01000;
      end
      4'b0110: begin
        s_out = ~(A & B);
        s_fl  = 5'b01000;
      end
      4'b0111: begin
        s_out = ~(A | B);
        s_fl  = 5'b01000;
      end
      4'b1000: begin
        s_out = A ^ B;
        s_fl  = 5'b01000;
      end
      4'b1001: begin
        s_out = ~(A ^ B);
        s_fl  = 5'b01000;
      end
      4'b1010: begin
        s_out = (A == B) ? WIDTH'(1) : '0;
        s_fl  = 5'b00100;
      end
      4'b1011: begin
        s_out = (A > B) ? WIDTH'(2) : '0;
        s_fl  = 5'b00100;
      end
      4'b1100: begin
        s_out = (A < B) ? WIDTH'(3) : '0;
        s_fl  = 5'b00100;
      end
      4'b1101: begin
        s_out = A >> sh;
        s_fl  = 5'b00010;
      end
      4'b1110: begin
        s_out = A << sh;
        s_fl  = 5'b00010;
      end
      default: begin
        s_out = '0;
        s_fl  = 5'b00000;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID  <= 1'b0;
      ALU_OUT    <= '0;
      ALU_REM    <= '0;
      Arith_Flag <= 1'b0;
      Logic_Flag <= 1'b0;
      Cmp_Flag   <= 1'b0;
      Shift_Flag <= 1'b0;
      Div0_Flag  <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      if (div_done) begin
        OUT_VALID  <= 1'b1;
        ALU_OUT    <= p_q[WIDTH-1:0];
        ALU_REM    <= p_q[2*WIDTH-1:WIDTH];
        Arith_Flag <= 1'b1;
        Logic_Flag <= 1'b0;
        Cmp_Flag   <= 1'b0;
        Shift_Flag <= 1'b0;
        Div0_Flag  <= 1'b0;
      end else if (accept && !start_div) begin
        OUT_VALID  <= 1'b1;
        ALU_OUT    <= s_out;
        ALU_REM    <= s_rem;
        Arith_Flag <= s_fl[4];
        Logic_Flag <= s_fl[3];
        Cmp_Flag   <= s_fl[2];
        Shift_Flag <= s_fl[1];
        Div0_Flag  <= s_fl[0];
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: vector table, hand sequences and random ops
// checked against an arithmetic reference model.
module tb_alu_mc;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   ALU_FUN;
  logic         OUT_VALID;
  logic [W-1:0] ALU_OUT;
  logic [W-1:0] ALU_REM;
  logic         Arith_Flag;
  logic         Logic_Flag;
  logic         Cmp_Flag;
  logic         Shift_Flag;
  logic         Div0_Flag;

  int n_chk  = 0;
  int n_fail = 0;

  alu_mc #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .ALU_FUN   (ALU_FUN),
    .OUT_VALID (OUT_VALID),
    .ALU_OUT   (ALU_OUT),
    .ALU_REM   (ALU_REM),
    .Arith_Flag(Arith_Flag),
    .Logic_Flag(Logic_Flag),
    .Cmp_Flag  (Cmp_Flag),
    .Shift_Flag(Shift_Flag),
    .Div0_Flag (Div0_Flag)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string        nm;
    logic [3:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] o;
    logic [W-1:0] r;
    logic [4:0]   fl;
  } vec_t;

  vec_t tbl[$];

  logic [3:0]   bb_f[4];
  logic [W-1:0] bb_a[4];
  logic [W-1:0] bb_b[4];
  logic [W-1:0] bb_o[4];
  logic [4:0]   bb_fl[4];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] fl_now();
    return {Arith_Flag, Logic_Flag, Cmp_Flag, Shift_Flag, Div0_Flag};
  endfunction

  task automatic model(input logic [3:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, output logic [W-1:0] o,
                       output logic [W-1:0] r, output logic [4:0] fl);
    longint ua;
    longint ub;
    longint m;
    longint res;
    longint rm;
    ua  = longint'(a);
    ub  = longint'(b);
    m   = (64'd1 << W) - 1;
    res = 0;
    rm  = 0;
    fl  = 5'b0;
    case (f)
      4'd0:  res = ua + ub;
      4'd1:  res = ua - ub;
      4'd2:  res = ua * ub;
      4'd3:  if (ub == 0) begin
               res = m;
               rm  = ua;
             end else begin
               res = ua / ub;
               rm  = ua % ub;
             end
      4'd4:  res = ua & ub;
      4'd5:  res = ua | ub;
      4'd6:  res = ~(ua & ub);
      4'd7:  res = ~(ua | ub);
      4'd8:  res = ua ^ ub;
      4'd9:  res = ~(ua ^ ub);
      4'd10: res = (ua == ub) ? 1 : 0;
      4'd11: res = (ua > ub) ? 2 : 0;
      4'd12: res = (ua < ub) ? 3 : 0;
      4'd13: res = ua >> (ub % W);
      4'd14: res = ua << (ub % W);
      default: res = 0;
    endcase
    if (f <= 3) fl[4] = 1'b1;
    else if (f <= 9) fl[3] = 1'b1;
    else if (f <= 12) fl[2] = 1'b1;
    else if (f <= 14) fl[1] = 1'b1;
    if (f == 3 && ub == 0) fl[0] = 1'b1;
    o = W'(res & m);
    r = W'(rm);
  endtask

  task automatic run_op(input string nm, input logic [3:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eo, input logic [W-1:0] er,
                        input logic [4:0] efl);
    int  wt;
    int  e;
    int  low;
    bit  isdiv;
    wt = 0;
    while (!IN_READY && wt < 100) begin
      step();
      wt++;
    end
    chk({nm, "_ready_in"}, 32'(IN_READY), 1);
    IN_VALID = 1'b1;
    ALU_FUN  = f;
    A        = a;
    B        = b;
    step();
    IN_VALID = 1'b0;
    A        = W'($urandom);
    B        = W'($urandom);
    ALU_FUN  = 4'($urandom);
    e   = 0;
    low = 0;
    while (!OUT_VALID && e < 40) begin
      if (!IN_READY) low++;
      step();
      e++;
    end
    isdiv = (f == 4'd3) && (b != '0);
    chk({nm, "_valid"}, 32'(OUT_VALID), 1);
    chk({nm, "_latency"}, e, isdiv ? W + 1 : 0);
    chk({nm, "_busy"}, low, isdiv ? W + 1 : 0);
    chk({nm, "_out"}, 32'(ALU_OUT), 32'(eo));
    chk({nm, "_rem"}, 32'(ALU_REM), 32'(er));
    chk({nm, "_flags"}, 32'(fl_now()), 32'(efl));
    chk({nm, "_ready_out"}, 32'(IN_READY), 1);
    step();
    chk({nm, "_strobe"}, 32'(OUT_VALID), 0);
    chk({nm, "_hold"}, 32'(ALU_OUT), 32'(eo));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [3:0]   rf;
    logic [W-1:0] mo;
    logic [W-1:0] mr;
    logic [4:0]   mfl;
    int           nv;
    int           wt;

    tbl.push_back(vec_t'{"div_1000_7", 4'h3, 16'd1000, 16'd7,
                         16'd142, 16'd6, 5'b10000});
    tbl.push_back(vec_t'{"div0", 4'h3, 16'h1234, 16'h0000,
                         16'hFFFF, 16'h1234, 5'b10001});
    tbl.push_back(vec_t'{"shl", 4'hE, 16'h0001, 16'h000F,
                         16'h8000, 16'h0, 5'b00010});
    tbl.push_back(vec_t'{"shr", 4'hD, 16'h8000, 16'h0014,
                         16'h0800, 16'h0, 5'b00010});
    tbl.push_back(vec_t'{"gt", 4'hB, 16'd5, 16'd3,
                         16'd2, 16'h0, 5'b00100});
    tbl.push_back(vec_t'{"lt", 4'hC, 16'd5, 16'd3,
                         16'd0, 16'h0, 5'b00100});
    tbl.push_back(vec_t'{"undef", 4'hF, 16'hFFFF, 16'hFFFF,
                         16'h0, 16'h0, 5'b00000});
    tbl.push_back(vec_t'{"eq", 4'hA, 16'd7, 16'd7,
                         16'd1, 16'h0, 5'b00100});
    tbl.push_back(vec_t'{"nand", 4'h6, 16'hF0F0, 16'hFF00,
                         16'h0FFF, 16'h0, 5'b01000});
    tbl.push_back(vec_t'{"nor", 4'h7, 16'h0F0F, 16'h00F0,
                         16'hF000, 16'h0, 5'b01000});
    tbl.push_back(vec_t'{"xnor", 4'h9, 16'hF0F0, 16'hFF00,
                         16'hF00F, 16'h0, 5'b01000});
    tbl.push_back(vec_t'{"mul_max", 4'h2, 16'hFFFF, 16'hFFFF,
                         16'h0001, 16'h0, 5'b10000});
    tbl.push_back(vec_t'{"sub_wrap", 4'h1, 16'd3, 16'd5,
                         16'hFFFE, 16'h0, 5'b10000});
    tbl.push_back(vec_t'{"div_big", 4'h3, 16'hFFFF, 16'h8001,
                         16'h0001, 16'h7FFE, 5'b10000});
    tbl.push_back(vec_t'{"div_small", 4'h3, 16'd5, 16'd9,
                         16'd0, 16'd5, 5'b10000});
    tbl.push_back(vec_t'{"div_one", 4'h3, 16'hFFFF, 16'd1,
                         16'hFFFF, 16'd0, 5'b10000});

    bb_f  = '{4'h0, 4'h1, 4'h2, 4'h8};
    bb_a  = '{16'hFFFF, 16'h0000, 16'h0100, 16'hF0F0};
    bb_b  = '{16'h0002, 16'h0001, 16'h0100, 16'hFF00};
    bb_o  = '{16'h0001, 16'hFFFF, 16'h0000, 16'h0FF0};
    bb_fl = '{5'b10000, 5'b10000, 5'b10000, 5'b01000};

    RST      = 1'b1;
    IN_VALID = 1'b0;
    A        = '0;
    B        = '0;
    ALU_FUN  = '0;
    step();
    step();
    RST = 1'b0;
    chk("rst_valid", 32'(OUT_VALID), 0);
    chk("rst_out", 32'(ALU_OUT), 0);
    chk("rst_rem", 32'(ALU_REM), 0);
    chk("rst_flags", 32'(fl_now()), 0);
    chk("rst_ready", 32'(IN_READY), 1);

    for (int i = 0; i < 4; i++) begin
      IN_VALID = 1'b1;
      ALU_FUN  = bb_f[i];
      A        = bb_a[i];
      B        = bb_b[i];
      step();
      chk($sformatf("b2b%0d_valid", i), 32'(OUT_VALID), 1);
      chk($sformatf("b2b%0d_out", i), 32'(ALU_OUT), 32'(bb_o[i]));
      chk($sformatf("b2b%0d_flags", i), 32'(fl_now()),
          32'(bb_fl[i]));
    end
    IN_VALID = 1'b0;
    step();
    chk("b2b_end_valid", 32'(OUT_VALID), 0);

    foreach (tbl[i]) begin
      run_op(tbl[i].nm, tbl[i].f, tbl[i].a, tbl[i].b,
             tbl[i].o, tbl[i].r, tbl[i].fl);
    end

    wt = 0;
    while (!IN_READY && wt < 100) begin
      step();
      wt++;
    end
    IN_VALID = 1'b1;
    ALU_FUN  = 4'h3;
    A        = 16'd1000;
    B        = 16'd7;
    step();
    IN_VALID = 1'b0;
    repeat (4) step();
    chk("abort_busy", 32'(IN_READY), 0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("abort_valid", 32'(OUT_VALID), 0);
    chk("abort_out", 32'(ALU_OUT), 0);
    chk("abort_rem", 32'(ALU_REM), 0);
    chk("abort_flags", 32'(fl_now()), 0);
    chk("abort_ready", 32'(IN_READY), 1);
    nv = 0;
    for (int i = 0; i < 25; i++) begin
      if (OUT_VALID) nv++;
      step();
    end
    chk("abort_no_result", nv, 0);
    run_op("after_abort", 4'h0, 16'd2, 16'd3,
           16'd5, 16'd0, 5'b10000);

    for (int i = 0; i < 200; i++) begin
      rf = 4'($urandom_range(0, 15));
      ra = W'($urandom);
      rb = W'($urandom);
      if (rf == 4'h3 && $urandom_range(0, 3) == 0) rb = '0;
      if (rf >= 4'hA && rf <= 4'hC && $urandom_range(0, 3) == 0)
        rb = ra;
      model(rf, ra, rb, mo, mr, mfl);
      run_op($sformatf("rnd%0d_op%0h", i, rf), rf, ra, rb,
             mo, mr, mfl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
